// File: rtl/sipo_load_ctrl_if.sv
// Handshake bundle between the byte source/consumer and sipo_load_ctrl.
// The timeout strobe exists only when SIPO_LOAD_TIMEOUT_EN is defined.
interface sipo_load_ctrl_if #(
  parameter int unsigned IWIDTH  = 10,
  parameter int unsigned NINPUTS = 8
);
  localparam int unsigned CW = $clog2(NINPUTS + 1);

  logic              load_req;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              shift_en;
  logic [IWIDTH-1:0] shift_data;
  logic              busy;
  logic [CW-1:0]     elem_cnt;
  logic              vec_done;
  logic              range_err;
`ifdef SIPO_LOAD_TIMEOUT_EN
  logic              timeout;
`endif

  modport master (
`ifdef SIPO_LOAD_TIMEOUT_EN
    output timeout,
`endif
    input  load_req, rx_data, rx_valid,
    output shift_en, shift_data, busy, elem_cnt, vec_done, range_err
  );

  modport slave (
`ifdef SIPO_LOAD_TIMEOUT_EN
    input  timeout,
`endif
    output load_req, rx_data, rx_valid,
    input  shift_en, shift_data, busy, elem_cnt, vec_done, range_err
  );
endinterface

// File: rtl/sipo_load_ctrl.sv
// Assembles low/high byte pairs into IWIDTH-bit elements and shifts NINPUTS of them
// into a SIPO vector register. Optional inter-byte timeout: define SIPO_LOAD_TIMEOUT_EN.
module sipo_load_ctrl #(
  parameter int unsigned IWIDTH  = 10,
  parameter int unsigned NINPUTS = 8
`ifdef SIPO_LOAD_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 100000
`endif
) (
  input logic              clk,
  input logic              rst,
  sipo_load_ctrl_if.master bus
);
  localparam int unsigned   CW   = $clog2(NINPUTS + 1);
  localparam logic [CW-1:0] LAST = CW'(NINPUTS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LO,
    WAIT_HI,
    SHIFT,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     elem_cnt_q, elem_cnt_d;
  logic [7:0]        lo_q, lo_d;
  logic [IWIDTH-1:0] shift_data_q, shift_data_d;
  logic              range_err_q, range_err_d;

`ifdef SIPO_LOAD_TIMEOUT_EN
  localparam int unsigned   TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          timeout_q, timeout_d;
`endif

  always_comb begin
    state_d      = state_q;
    elem_cnt_d   = elem_cnt_q;
    lo_d         = lo_q;
    shift_data_d = shift_data_q;
    range_err_d  = range_err_q;
`ifdef SIPO_LOAD_TIMEOUT_EN
    tcnt_d       = tcnt_q;
    timeout_d    = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.load_req) begin
          state_d     = WAIT_LO;
          elem_cnt_d  = '0;
          range_err_d = 1'b0;
`ifdef SIPO_LOAD_TIMEOUT_EN
          tcnt_d      = '0;
`endif
        end
      end

      WAIT_LO: begin
        if (bus.rx_valid) begin
          lo_d    = bus.rx_data;
          state_d = WAIT_HI;
`ifdef SIPO_LOAD_TIMEOUT_EN
          tcnt_d  = '0;
        end else if (tcnt_q == TLAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
`endif
        end
      end

      WAIT_HI: begin
        if (bus.rx_valid) begin
          // High byte bits above the element width are dropped but flagged.
          shift_data_d = IWIDTH'({bus.rx_data, lo_q});
          if ((bus.rx_data >> (IWIDTH - 8)) != 8'd0) begin
            range_err_d = 1'b1;
          end
          state_d = SHIFT;
`ifdef SIPO_LOAD_TIMEOUT_EN
          tcnt_d  = '0;
        end else if (tcnt_q == TLAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
`endif
        end
      end

      SHIFT: begin
        elem_cnt_d = elem_cnt_q + CW'(1);
        if (elem_cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          state_d = WAIT_LO;
`ifdef SIPO_LOAD_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      elem_cnt_q   <= '0;
      lo_q         <= '0;
      shift_data_q <= '0;
      range_err_q  <= 1'b0;
`ifdef SIPO_LOAD_TIMEOUT_EN
      tcnt_q       <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      elem_cnt_q   <= elem_cnt_d;
      lo_q         <= lo_d;
      shift_data_q <= shift_data_d;
      range_err_q  <= range_err_d;
`ifdef SIPO_LOAD_TIMEOUT_EN
      tcnt_q       <= tcnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign bus.shift_en   = (state_q == SHIFT);
  assign bus.vec_done   = (state_q == DONE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.shift_data = shift_data_q;
  assign bus.elem_cnt   = elem_cnt_q;
  assign bus.range_err  = range_err_q;
`ifdef SIPO_LOAD_TIMEOUT_EN
  assign bus.timeout    = timeout_q;
`endif
endmodule

// File: doc/sipo_load_ctrl.md
Name: sipo_load_ctrl

Overview:
- Sequences a serial-in/parallel-out vector register (shiftSipoMem-style: IWIDTH-bit elements, NINPUTS deep, single shift enable).
- Takes a byte stream from the UART receiver and assembles each element from two bytes, low byte first.
- Drives the register's enable and data for exactly one cycle per element.
- Pulses vec_done once NINPUTS elements have been shifted, so the downstream compute stage can consume the full parallel vector.

Parameters:
- IWIDTH, 10, element width in bits; legal range 9..16.
- NINPUTS, 8, elements per vector; legal range 2..1024.
- TIMEOUT_CYCLES, 100000, inter-byte timeout in clocks (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load_req  in  1  one-cycle pulse that starts loading a vector.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data is valid this cycle (one-cycle strobe per byte).
- shift_en  out  1  enable to the SIPO register; one cycle per element.
- shift_data  out  IWIDTH  element presented to the SIPO, valid while shift_en=1.
- busy  out  1  high in every state except IDLE.
- elem_cnt  out  clog2(NINPUTS+1)  number of elements shifted in the current load.
- vec_done  out  1  one-cycle pulse after the last element is shifted.
- range_err  out  1  sticky flag: a high byte had nonzero bits above IWIDTH-8.

Behaviour:
- Reset (synchronous, highest priority):
  - State goes to IDLE.
  - shift_en, vec_done, busy, range_err, elem_cnt and shift_data all go to 0.
  - Reset mid-load abandons the vector. The SIPO contents are left as they are; only the controller resets.
- FSM states: IDLE, WAIT_LO, WAIT_HI, SHIFT, DONE.
- IDLE:
  - load_req=1 → WAIT_LO; clear elem_cnt and range_err.
  - rx_valid is ignored.
- WAIT_LO:
  - rx_valid=1 → latch lo=rx_data → WAIT_HI.
- WAIT_HI:
  - rx_valid=1 → shift_data <= {rx_data, lo}[IWIDTH-1:0] → SHIFT.
  - If rx_data[7:IWIDTH-8] is nonzero, set range_err; the excess bits are discarded.
- SHIFT (exactly one cycle):
  - shift_en=1 and elem_cnt increments.
  - If the incremented count equals NINPUTS → DONE, otherwise → WAIT_LO.
  - An rx_valid arriving during SHIFT is dropped. The upstream producer guarantees at least 2 idle cycles between bytes; a UART at any practical baud rate satisfies this.
- DONE (one cycle):
  - vec_done=1 → IDLE.
  - elem_cnt holds NINPUTS until the next load_req.
- load_req while busy=1 is ignored; no restart and no queueing.
- shift_data holds its last value when shift_en=0.
- Latency:
  - Second byte's rx_valid at edge N → shift_en high in cycle N+1.
  - Last element's shift_en at cycle M → vec_done at cycle M+1.
- A load always ends with exactly NINPUTS shift_en pulses unless reset or timeout intervenes. No partial vector is ever signalled done.

Optional Feature:
- Macro: SIPO_LOAD_TIMEOUT_EN.
- When defined:
  - A timeout counter clears on entry to WAIT_LO/WAIT_HI and on every rx_valid.
  - It increments every cycle spent in WAIT_LO or WAIT_HI.
  - On reaching TIMEOUT_CYCLES the FSM returns to IDLE without vec_done and asserts an extra output timeout (1 bit) for one cycle.
  - elem_cnt retains the partial count for debug.
- When undefined:
  - The timeout port and the counter are absent.
  - The FSM waits indefinitely in WAIT_LO/WAIT_HI.

Test Plan (IWIDTH=10, NINPUTS=8):
- Basic load: load_req, then byte pairs (i,0x00) for i=1..8 → 8 shift_en pulses with shift_data 1,2,...,8 in order; vec_done one cycle after the 8th pulse; elem_cnt=8; busy=0 afterwards; range_err=0.
- Width and range: pair (0xFF,0x03) → shift_data=0x3FF, range_err=0. Pair (0x34,0x86) → shift_data=0x234, range_err=1, and it stays 1 until the next load_req.
- Ignored inputs: rx_valid with 0xAA while IDLE → no shift_en. load_req pulsed after the 3rd element → load continues, total of 8 pulses, single vec_done.
- Reset mid-operation: rst asserted after 5 elements → next cycle busy=0, elem_cnt=0, no vec_done. A new load then completes normally with 8 pulses.
- Back-to-back vectors: load_req in the cycle after vec_done → second load accepted; elem_cnt restarts at 0.
- With SIPO_LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=50: send only the low byte of element 4 and then stall → timeout pulses 50 cycles after that byte; state returns to IDLE; elem_cnt=3; no vec_done.
